// File: rtl/snd_wr_pkg.sv
// Shared encodings for the sound-chip write initiator: command targets, FSM states
// and the FIFO entry layout.
package snd_wr_pkg;

    typedef enum logic [1:0] {
        TGT_YM_ADDR = 2'd0,
        TGT_YM_DATA = 2'd1,
        TGT_OKI     = 2'd2,
        TGT_BANK    = 2'd3
    } tgt_e;

    localparam int unsigned CMD_W = 10;

    typedef struct packed {
        tgt_e       tgt;
        logic [7:0] data;
    } cmd_t;

    typedef enum logic [2:0] {
        StIdle,
        StDispatch,
        StYmPoll,
        StYmWr,
        StOkiWr,
        StGap
    } state_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/snd_cmd_fifo.sv
// DEPTH x WIDTH synchronous FIFO with combinational head read and simultaneous push/pop.
// full_next is the full flag one cycle ahead, so the caller can register its ready.
module snd_cmd_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full,
    output logic             full_next
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_pop  = pop && !empty;
    // A push into a full FIFO only lands when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (!do_push && do_pop) begin
            count_d = count_q - 1'b1;
        end
    end

    assign full_next = (count_d == (AW+1)'(DEPTH));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/snowbro2_snd_wr.sv
// Sound-chip write initiator: queues register writes and drives jt51 / jt6295 strobes
// with fixed hold and gap timing, polling YM busy before data writes.
module snowbro2_snd_wr
    import snd_wr_pkg::*;
#(
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned WR_CYC   = 8,
    parameter int unsigned GAP_CYC  = 4,
    parameter int unsigned OKI_HOLD = 64,
    parameter int unsigned BUSY_TMO = 4096
) (
    input  logic       CLK96,
    input  logic       RESET96_N,
    input  logic       CMD_VALID,
    output logic       CMD_READY,
    input  logic [1:0] CMD_TGT,
    input  logic [7:0] CMD_DATA,
    output logic       YM2151_CS,
    output logic       YM2151_WE,
    output logic       YM2151_WR_CMD,
    output logic [7:0] YM2151_DIN,
    input  logic [7:0] YM2151_DOUT,
    output logic       OKI_WE,
    output logic [7:0] OKI_DIN,
    output logic       OKI_BANK,
    output logic       IDLE,
    output logic       TMO_ERR
);

    localparam int unsigned CNT_W =
        $clog2(max_u(max_u(WR_CYC, GAP_CYC), max_u(OKI_HOLD, BUSY_TMO))) + 1;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    cmd_t               cmd_q, cmd_d;
    logic               ready_q;
    logic               bank_q, bank_d;
    logic               tmo_q, tmo_d;
    logic [7:0]         ym_din_q, oki_din_q;

    logic               fifo_push, fifo_pop, fifo_empty, fifo_full, fifo_full_next;
    logic [CMD_W-1:0]   fifo_rdata;
    logic               unused;

    assign unused    = ^{YM2151_DOUT[6:0], fifo_full};
    assign fifo_push = CMD_VALID && ready_q;

    snd_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk       (CLK96),
        .rst_n     (RESET96_N),
        .push      (fifo_push),
        .wdata     ({CMD_TGT, CMD_DATA}),
        .pop       (fifo_pop),
        .rdata     (fifo_rdata),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .full_next (fifo_full_next)
    );

    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        bank_d   = bank_q;
        tmo_d    = tmo_q;
        fifo_pop = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    cmd_d    = cmd_t'(fifo_rdata);
                    state_d  = StDispatch;
                end
            end
            StDispatch: begin
                unique case (cmd_q.tgt)
                    TGT_BANK: begin
                        bank_d  = cmd_q.data[0];
                        state_d = StIdle;
                    end
                    TGT_OKI:     state_d = StOkiWr;
                    TGT_YM_ADDR: state_d = StYmWr;
                    TGT_YM_DATA: state_d = StYmPoll;
                endcase
            end
            StYmPoll: begin
                // The first poll cycle only opens the status read; busy is trusted from cycle 2.
                if (cnt_q != '0 && !YM2151_DOUT[7]) begin
                    state_d = StYmWr;
                end else if (cnt_q == CNT_W'(BUSY_TMO - 1)) begin
                    tmo_d   = 1'b1;
                    state_d = StYmWr;
                end
            end
            StYmWr:  if (cnt_q == CNT_W'(WR_CYC - 1))   state_d = StGap;
            StOkiWr: if (cnt_q == CNT_W'(OKI_HOLD - 1)) state_d = StGap;
            StGap:   if (cnt_q == CNT_W'(GAP_CYC - 1))  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        cnt_d = (state_d != state_q) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge CLK96) begin
        if (!RESET96_N) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            cmd_q     <= '0;
            ready_q   <= 1'b0;
            bank_q    <= 1'b0;
            tmo_q     <= 1'b0;
            ym_din_q  <= '0;
            oki_din_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cmd_q   <= cmd_d;
            ready_q <= !fifo_full_next;
            bank_q  <= bank_d;
            tmo_q   <= tmo_d;
            if (state_d == StYmWr && state_q != StYmWr)   ym_din_q  <= cmd_q.data;
            if (state_d == StOkiWr && state_q != StOkiWr) oki_din_q <= cmd_q.data;
        end
    end

    assign CMD_READY     = ready_q;
    assign YM2151_CS     = (state_q == StYmPoll) || (state_q == StYmWr);
    assign YM2151_WE     = (state_q != StYmWr);
    assign YM2151_WR_CMD = (state_q == StYmPoll) ||
                           ((state_q == StYmWr) && (cmd_q.tgt == TGT_YM_DATA));
    assign YM2151_DIN    = ym_din_q;
    assign OKI_WE        = (state_q != StOkiWr);
    assign OKI_DIN       = oki_din_q;
    assign OKI_BANK      = bank_q;
    assign IDLE          = fifo_empty && (state_q == StIdle);
    assign TMO_ERR       = tmo_q;

endmodule

// File: doc/snowbro2_snd_wr.md
Name: snowbro2_snd_wr

Overview:
- Bus-initiator side of the sound chip register interface.
- Accepts queued register-write commands from the sound CPU glue and drives the YM2151 (jt51) and OKI M6295 (jt6295) write strobes with the correct timing.
- Polls the YM2151 busy flag before each YM data write; also owns the OKI bank latch.
- Sits in the CLK96 domain, directly in front of the sound mixer block.

Parameters:
- DEPTH, 16, command FIFO entries (power of two, ≥2)
- WR_CYC, 8, CLK96 cycles each write strobe is held active
- GAP_CYC, 4, idle cycles after each strobe before the next access
- OKI_HOLD, 64, OKI_WE low time in cycles; must span ≥1 OKI_CEN period
- BUSY_TMO, 4096, maximum poll cycles waiting for YM busy to clear

Ports:
- CLK96 in 1: sole clock
- RESET96_N in 1: synchronous, active-low reset
- CMD_VALID in 1: command present
- CMD_READY out 1: FIFO can accept; push when VALID&READY
- CMD_TGT in 2: 0=YM address, 1=YM data, 2=OKI, 3=OKI bank
- CMD_DATA in 8: register address or data byte
- YM2151_CS out 1: active-high chip select
- YM2151_WE out 1: active-low write strobe
- YM2151_WR_CMD out 1: a0; 0=address, 1=data
- YM2151_DIN out 8: write data
- YM2151_DOUT in 8: status; bit7=busy
- OKI_WE out 1: active-low write strobe
- OKI_DIN out 8: write data
- OKI_BANK out 1: ROM bank bit
- IDLE out 1: FIFO empty and FSM in S_IDLE
- TMO_ERR out 1: sticky busy-timeout flag; cleared only by reset

Behaviour:
- Reset (RESET96_N low at a CLK96 edge):
  - Outputs: YM2151_CS=0, YM2151_WE=1, YM2151_WR_CMD=0, YM2151_DIN=0, OKI_WE=1, OKI_DIN=0, OKI_BANK=0, TMO_ERR=0, CMD_READY=0 during reset, IDLE=1.
  - FIFO emptied, FSM forced to S_IDLE, all counters cleared.
  - Reset mid-strobe deasserts the strobe on the next edge; pending commands are discarded.
- FIFO:
  - Entries are {TGT, DATA}. CMD_READY = !full, registered.
  - Push while full is ignored.
  - Simultaneous push and pop when full is allowed; count is unchanged.
  - Pointers wrap modulo DEPTH.
- FSM:
  - S_IDLE: if FIFO not empty, pop the head into the cmd register and go to S_DISPATCH. Pop-to-strobe latency is 2 cycles.
  - S_DISPATCH:
    - TGT=3: set OKI_BANK<=DATA[0] in one cycle, then S_IDLE. No gap.
    - TGT=2: go to S_OKI_WR.
    - TGT=0: go to S_YM_WR.
    - TGT=1: go to S_YM_POLL.
  - S_YM_POLL:
    - YM2151_CS=1, YM2151_WE=1, WR_CMD=1.
    - Sample YM2151_DOUT[7] each cycle from the 2nd poll cycle onward. When it reads 0, go to S_YM_WR.
    - When the poll counter reaches BUSY_TMO, set TMO_ERR and go to S_YM_WR anyway.
  - S_YM_WR:
    - CS=1, WE=0, WR_CMD=(TGT==1), DIN=DATA, held exactly WR_CYC cycles.
    - Then go to S_GAP with CS=0, WE=1.
  - S_OKI_WR: OKI_WE=0, OKI_DIN=DATA, held exactly OKI_HOLD cycles, then S_GAP.
  - S_GAP: all strobes inactive for GAP_CYC cycles, then S_IDLE.
- Hold rules:
  - DIN values hold their last written value after the strobe.
  - YM and OKI strobes are never active in the same cycle.
- Ordering: commands are issued strictly in FIFO order; no reordering between chips.
- Counters are sized as $clog2 of the largest parameter +1 and are reloaded on every state entry.

Decomposition:
- Package snd_wr_pkg: TGT encodings (TGT_YM_ADDR, TGT_YM_DATA, TGT_OKI, TGT_BANK), FSM state enum, cmd entry struct width (10 bits).
- Sub-module snd_cmd_fifo: parameterised DEPTH×10 synchronous FIFO with full/empty and simultaneous push/pop.

Test Plan:
- Reset with CMD_VALID=1 → CMD_READY=0, strobes inactive, OKI_BANK=0. After release, READY=1 on the next cycle.
- Push YM addr 0x28 then YM data 0x4A with DOUT[7]=1 for 20 cycles, then 0 → WE low 8 cycles at WR_CMD=0, DIN=0x28. Then a poll of ≥20 cycles, then WE low 8 cycles with WR_CMD=1, DIN=0x4A.
- Push OKI 0x80 → OKI_WE low exactly 64 cycles with OKI_DIN=0x80. YM2151_CS stays 0 throughout.
- Push bank 0x01 between two OKI writes → OKI_BANK=1 asserted after the first OKI write's gap and before the second strobe.
- Hold DOUT[7]=1 permanently, then push YM data → after 4096 poll cycles TMO_ERR=1 and the write still occurs. TMO_ERR stays 1 until reset.
- Push 17 commands back-to-back with DEPTH=16 → READY drops at 16 entries. The 17th is accepted only after the first pop, and all 17 issue in order. Assert reset during the 5th strobe → strobe inactive the next cycle and FIFO empty.
